instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit.
//   - Default widths and reset PC used as parameter defaults by instr_fetch_unit
//   - Fetch FSM state encoding
//   - word_bytes(): bytes per instruction word, i.e. the PC increment
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned DefaultAddrWidth = 14;
    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultResetPc   = 0;

    // StIdle : no request outstanding
    // StFetch: request outstanding, the returned word is kept
    // StDrain: request outstanding, the returned word is thrown away
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } fetch_state_e;

    function automatic int unsigned word_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO used as the prefetch buffer. Flush empties the buffer and
// takes priority over a push in the same cycle. Depth must be a power of two
// so the pointers wrap naturally.
// Ports:
//   clock, reset_n    : clock, asynchronous active-low reset
//   flush             : discard all entries
//   push, push_data   : write an entry (ignored when full and not popping)
//   pop, pop_data     : remove the head entry; pop_data shows the head
//   empty, full       : occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PtrW + 1)'(Depth));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Storage is cleared so the head reads as zero straight out of reset.
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Sequential instruction prefetcher with one outstanding memory request and a
// FIFO_DEPTH-entry buffer toward decode. Redirects flush the buffer and
// restart fetching at the (word-aligned) redirect address; a request that is
// in flight at redirect time is drained and its data dropped.
// Ports:
//   clock, reset_n               : clock, asynchronous active-low reset
//   mem_req, mem_addr            : fetch request and byte address
//   mem_ack, mem_rdata           : one-cycle response strobe and data
//   redirect_valid, redirect_pc  : branch/exception redirect
//   instr_valid, instr_ready     : handshake toward decode
//   instr_data, instr_pc         : buffered word at the FIFO head and its address
//   fetch_pc                     : address of the next request to issue
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned           DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DefaultResetPc)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] fetch_pc
);

    localparam int unsigned           Step      = word_bytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] StepA     = ADDR_WIDTH'(Step);
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(Step - 1);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  push, pop;
    logic                  fifo_empty, fifo_full;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                // Only one request in flight, so a free slot now guarantees room
                // for its data when it returns.
                if (!redirect_valid && !fifo_full) begin
                    state_d = StFetch;
                    addr_d  = fetch_pc_q;
                end
            end
            StFetch: begin
                if (mem_ack) begin
                    state_d = StIdle;
                    push    = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Additions wrap modulo 2^ADDR_WIDTH by construction.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & AlignMask;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + StepA;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    assign mem_req     = (state_q != StIdle);
    assign mem_addr    = addr_q;
    assign fetch_pc    = fetch_pc_q;
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;

    fetch_fifo #(
        .Width(DATA_WIDTH + ADDR_WIDTH),
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .push     (push),
        .push_data({mem_rdata, addr_q}),
        .pop      (pop),
        .pop_data ({instr_data, instr_pc}),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule
